// File: rtl/game_pkg.sv
// Shared game definitions: fighter FSM state encodings, screen/sprite geometry
// and the attack-kind classification used by the hit resolver.
package game_pkg;

    // Fighter movement/attack FSM encodings, shared with the fighter FSM.
    localparam logic [2:0] FS_IDLE       = 3'd0;
    localparam logic [2:0] FS_FWD        = 3'd1;
    localparam logic [2:0] FS_BWD        = 3'd2;
    localparam logic [2:0] FS_ATTACK     = 3'd3;
    localparam logic [2:0] FS_DIR_ATTACK = 3'd4;
    localparam logic [2:0] FS_STARTUP    = 3'd5;
    localparam logic [2:0] FS_ACTIVE     = 3'd6;
    localparam logic [2:0] FS_RECOVERY   = 3'd7;

    localparam int unsigned SPRITE_W = 64;
    localparam int unsigned SCREEN_W = 640;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_BASIC,
        KIND_DIR
    } atk_kind_t;

    // Directional wins when both attack flags are raised.
    function automatic atk_kind_t attack_kind(input logic attacking, input logic dir_attacking);
        if (dir_attacking) begin
            return KIND_DIR;
        end else if (attacking) begin
            return KIND_BASIC;
        end
        return KIND_NONE;
    endfunction

endpackage

// File: rtl/stun_counter.sv
// Loadable down-counter holding at zero.
//   clk, reset (sync, active-low)
//   load, load_val : reload the counter (reload wins over the decrement)
//   count          : remaining frames
//   busy           : count != 0
module stun_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         busy
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hit_resolver.sv
// Resolves one attacker's active frames against one defender: decides whether
// the attack connects and whether it is a hit or a block, and tracks the
// defender's stun, health and KO.
//   clk, reset (sync, active-low)
//   atk_state, atk_x, atk_attacking, atk_dir_attacking : attacker FSM outputs
//   def_x, def_back                                    : defender position and guard
//   hit_pulse, block_pulse                             : one-cycle outcome pulses
//   def_stun, stun_left                                : defender stun status
//   def_health, ko                                     : defender health, sticky KO
module hit_resolver
    import game_pkg::*;
#(
    parameter int unsigned SPRITE_W        = game_pkg::SPRITE_W,
    parameter int unsigned REACH_BASIC     = 40,
    parameter int unsigned REACH_DIR       = 56,
    parameter int unsigned HITSTUN_BASIC   = 12,
    parameter int unsigned HITSTUN_DIR     = 10,
    parameter int unsigned BLOCKSTUN_BASIC = 6,
    parameter int unsigned BLOCKSTUN_DIR   = 4,
    parameter int unsigned HEALTH_INIT     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] atk_state,
    input  logic [9:0] atk_x,
    input  logic       atk_attacking,
    input  logic       atk_dir_attacking,
    input  logic [9:0] def_x,
    input  logic       def_back,
    output logic       hit_pulse,
    output logic       block_pulse,
    output logic       def_stun,
    output logic [4:0] stun_left,
    output logic [2:0] def_health,
    output logic       ko
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_LATCHED,
        R_KO
    } res_state_t;

    res_state_t state;
    atk_kind_t  kind;
    logic [10:0] ax, dx, reach;
    logic        facing_right, connect, resolve, blocked;
    logic [4:0]  stun_val;
    logic [2:0]  health_dec;

    assign kind = attack_kind(atk_attacking, atk_dir_attacking);

    // 11-bit arithmetic so position + sprite + reach never wraps.
    always_comb begin
        ax           = {1'b0, atk_x};
        dx           = {1'b0, def_x};
        reach        = (kind == KIND_DIR) ? 11'(REACH_DIR) : 11'(REACH_BASIC);
        facing_right = (atk_x <= def_x);
        if (facing_right) begin
            connect = (dx <= ax + 11'(SPRITE_W) + reach);
        end else begin
            connect = (ax <= dx + 11'(SPRITE_W) + reach);
        end
    end

    assign resolve = (state == R_IDLE) && (atk_state == FS_ACTIVE) && (kind != KIND_NONE)
                     && connect;
    // Any remaining stun, hit or block, prevents guarding.
    assign blocked = def_back && (stun_left == 5'd0);

    always_comb begin
        if (blocked) begin
            stun_val = (kind == KIND_DIR) ? 5'(BLOCKSTUN_DIR) : 5'(BLOCKSTUN_BASIC);
        end else begin
            stun_val = (kind == KIND_DIR) ? 5'(HITSTUN_DIR) : 5'(HITSTUN_BASIC);
        end
    end

    assign health_dec = (def_health == 3'd0) ? 3'd0 : def_health - 3'd1;

    stun_counter #(
        .W (5)
    ) u_stun (
        .clk      (clk),
        .reset    (reset),
        .load     (resolve),
        .load_val (stun_val),
        .count    (stun_left),
        .busy     (def_stun)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= R_IDLE;
            hit_pulse   <= 1'b0;
            block_pulse <= 1'b0;
            def_health  <= 3'(HEALTH_INIT);
            ko          <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            block_pulse <= 1'b0;
            unique case (state)
                R_IDLE: begin
                    if (resolve) begin
                        if (blocked) begin
                            block_pulse <= 1'b1;
                            state       <= R_LATCHED;
                        end else begin
                            hit_pulse  <= 1'b1;
                            def_health <= health_dec;
                            if (health_dec == 3'd0) begin
                                ko    <= 1'b1;
                                state <= R_KO;
                            end else begin
                                state <= R_LATCHED;
                            end
                        end
                    end
                end
                R_LATCHED: begin
                    if (atk_state != FS_ACTIVE) begin
                        state <= R_IDLE;
                    end
                end
                R_KO: begin
                    state <= R_KO;
                end
                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] atk_state = 3'd0;
    logic [9:0] atk_x = 10'd0;
    logic       atk_attacking = 1'b0;
    logic       atk_dir_attacking = 1'b0;
    logic [9:0] def_x = 10'd0;
    logic       def_back = 1'b0;
    logic       hit_pulse, block_pulse, def_stun, ko;
    logic [4:0] stun_left;
    logic [2:0] def_health;

    always #5 clk = ~clk;

    hit_resolver dut (
        .clk               (clk),
        .reset             (reset),
        .atk_state         (atk_state),
        .atk_x             (atk_x),
        .atk_attacking     (atk_attacking),
        .atk_dir_attacking (atk_dir_attacking),
        .def_x             (def_x),
        .def_back          (def_back),
        .hit_pulse         (hit_pulse),
        .block_pulse       (block_pulse),
        .def_stun          (def_stun),
        .stun_left         (stun_left),
        .def_health        (def_health),
        .ko                (ko)
    );

    typedef struct {
        logic       hit;
        logic       blk;
        logic [4:0] stun;
        logic [2:0] health;
        logic       ko;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: 0 idle, 1 latched, 2 ko
    int m_state = 0;
    int m_stun = 0;
    int m_health = 3;
    int m_ko = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one frame of inputs, predict the edge, then compare after it.
    task automatic step(input logic [2:0] st, input int ax, input logic atk, input logic dir,
                        input int dx, input logic back, input logic rst, input string tag);
        exp_t e;
        int   reach, conn, res, kind;
        atk_state         = st;
        atk_x             = ax[9:0];
        atk_attacking     = atk;
        atk_dir_attacking = dir;
        def_x             = dx[9:0];
        def_back          = back;
        reset             = rst;
        e.hit = 1'b0;
        e.blk = 1'b0;
        if (!rst) begin
            m_state = 0; m_stun = 0; m_health = 3; m_ko = 0;
        end else begin
            kind  = dir ? 2 : (atk ? 1 : 0);
            reach = (kind == 2) ? 56 : 40;
            if (ax <= dx) conn = (dx <= ax + 64 + reach);
            else          conn = (ax <= dx + 64 + reach);
            res = (m_state == 0) && (st == 3'd6) && (kind != 0) && conn;
            if (res) begin
                if (back && m_stun == 0) begin
                    e.blk   = 1'b1;
                    m_stun  = (kind == 2) ? 4 : 6;
                    m_state = 1;
                end else begin
                    e.hit    = 1'b1;
                    m_stun   = (kind == 2) ? 10 : 12;
                    m_health = (m_health > 0) ? m_health - 1 : 0;
                    if (m_health == 0) begin
                        m_ko = 1; m_state = 2;
                    end else begin
                        m_state = 1;
                    end
                end
            end else begin
                if (m_stun > 0) m_stun = m_stun - 1;
                if (m_state == 1 && st != 3'd6) m_state = 0;
            end
        end
        e.stun   = m_stun[4:0];
        e.health = m_health[2:0];
        e.ko     = m_ko[0];
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({tag, ".hit"}, 32'(hit_pulse), 32'(e.hit));
        check({tag, ".blk"}, 32'(block_pulse), 32'(e.blk));
        check({tag, ".stun"}, 32'(stun_left), 32'(e.stun));
        check({tag, ".stunflag"}, 32'(def_stun), 32'(e.stun != 5'd0));
        check({tag, ".health"}, 32'(def_health), 32'(e.health));
        check({tag, ".ko"}, 32'(ko), 32'(e.ko));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(3'd0, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, tag);
    endtask

    task automatic do_reset();
        step(3'd0, 100, 1'b0, 1'b0, 180, 1'b0, 1'b0, "rst");
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        do_reset();
        check("reset_health", 32'(def_health), 32'd3);
        check("reset_stun", 32'(stun_left), 32'd0);

        // Basic hit in range, then stun drains 12 -> 0
        step(3'd5, 100, 1'b1, 1'b0, 180, 1'b0, 1'b1, "basic_su");
        step(3'd6, 100, 1'b1, 1'b0, 180, 1'b0, 1'b1, "basic_act");
        check("basic_pulse", 32'(hit_pulse), 32'd1);
        check("basic_stun12", 32'(stun_left), 32'd12);
        check("basic_health2", 32'(def_health), 32'd2);
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "basic_rec");
        check("basic_pulse_once", 32'(hit_pulse), 32'd0);
        idle(12, "drain");
        check("drain_zero", 32'(stun_left), 32'd0);

        // Out of range basic (205 > 204), directional boundary hit at 220
        do_reset();
        step(3'd6, 100, 1'b1, 1'b0, 205, 1'b0, 1'b1, "oor_basic");
        check("oor_nopulse", 32'(hit_pulse), 32'd0);
        step(3'd7, 100, 1'b0, 1'b0, 205, 1'b0, 1'b1, "oor_rec");
        step(3'd6, 100, 1'b0, 1'b1, 220, 1'b0, 1'b1, "dir_edge");
        check("dir_edge_stun10", 32'(stun_left), 32'd10);
        step(3'd7, 100, 1'b0, 1'b0, 220, 1'b0, 1'b1, "dir_rec");
        // Both flags: directional priority, and no kind -> no resolution
        step(3'd6, 100, 1'b1, 1'b1, 180, 1'b0, 1'b1, "both");
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "both_rec");
        step(3'd6, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "nokind");
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "nokind_rec");

        // Block, then stunned defender cannot block
        do_reset();
        step(3'd6, 100, 1'b0, 1'b1, 180, 1'b1, 1'b1, "block");
        check("block_pulse", 32'(block_pulse), 32'd1);
        check("block_stun4", 32'(stun_left), 32'd4);
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b1, 1'b1, "block_rec");
        step(3'd6, 100, 1'b1, 1'b0, 180, 1'b1, 1'b1, "stunblk");
        check("stunblk_hit", 32'(hit_pulse), 32'd1);
        check("stunblk_stun12", 32'(stun_left), 32'd12);
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b1, 1'b1, "stunblk_rec");
        idle(13, "blk_drain");
        step(3'd6, 100, 1'b1, 1'b0, 180, 1'b1, 1'b1, "block_basic");
        check("block_basic_stun6", 32'(stun_left), 32'd6);
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b1, 1'b1, "block_basic_rec");

        // Single resolution per attack, re-entry allowed
        do_reset();
        step(3'd6, 100, 1'b0, 1'b1, 180, 1'b0, 1'b1, "hold1");
        step(3'd6, 100, 1'b0, 1'b1, 180, 1'b0, 1'b1, "hold2");
        check("hold_single", 32'(hit_pulse), 32'd0);
        step(3'd7, 100, 1'b0, 1'b1, 180, 1'b0, 1'b1, "hold_rec");
        step(3'd6, 100, 1'b0, 1'b1, 180, 1'b0, 1'b1, "reenter");
        check("reenter_hit", 32'(hit_pulse), 32'd1);
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "reenter_rec");

        // KO after three hits; nothing resolves afterwards, stun drains
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(3'd6, 100, 1'b1, 1'b0, 180, 1'b0, 1'b1, "ko_hit");
            step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "ko_rec");
        end
        check("ko_set", 32'(ko), 32'd1);
        check("ko_health0", 32'(def_health), 32'd0);
        step(3'd6, 100, 1'b1, 1'b0, 180, 1'b0, 1'b1, "ko_4th");
        check("ko_nopulse", 32'(hit_pulse), 32'd0);
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "ko_4th_rec");
        idle(4, "ko_drain");

        // Reset mid-stun at health 1
        do_reset();
        step(3'd6, 100, 1'b1, 1'b0, 180, 1'b0, 1'b1, "mid_h1");
        step(3'd7, 100, 1'b0, 1'b0, 180, 1'b0, 1'b1, "mid_r1");
        step(3'd6, 100, 1'b1, 1'b0, 180, 1'b0, 1'b1, "mid_h2");
        idle(5, "mid_wait");
        check("mid_stun7", 32'(stun_left), 32'd7);
        check("mid_health1", 32'(def_health), 32'd1);
        do_reset();
        check("mid_rst_stun", 32'(stun_left), 32'd0);
        check("mid_rst_health", 32'(def_health), 32'd3);

        // Facing left: 300 <= 304 connects, 305 does not
        step(3'd6, 300, 1'b1, 1'b0, 200, 1'b0, 1'b1, "left_hit");
        check("left_hit_pulse", 32'(hit_pulse), 32'd1);
        step(3'd7, 300, 1'b0, 1'b0, 200, 1'b0, 1'b1, "left_rec");
        step(3'd6, 305, 1'b1, 1'b0, 200, 1'b0, 1'b1, "left_miss");
        check("left_miss_pulse", 32'(hit_pulse), 32'd0);
        step(3'd7, 305, 1'b0, 1'b0, 200, 1'b0, 1'b1, "left_miss_rec");
        idle(2, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
